uart_rx_frame: RTL and testbench

Oversampling UART receiver: recovers 8N1 frames from the asynchronous `Rx` line using a programmable clocks-per-bit timer, mid-bit sampling, start-bit glitch rejection and stop-bit framing check. It presents each received byte through a one-entry holding register with a valid/ready handshake. It is the receive-side counterpart of the team's UART transmitter. It sits between the serial pin and the byte-wide system databus.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 28 ++
 rtl/uart_rx_frame.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_frame.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and defaults used by the receive path.
package uart_pkg;

  // Receiver frame-tracking states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for bringing an asynchronous pin into the clk domain.
// The reset value is a parameter so idle-high and idle-low lines can share it.
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first one a full cycle to settle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling 8N1 UART receiver with mid-bit sampling, start-glitch
// rejection, stop-bit framing check and a one-entry valid/ready holding register.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] databus_write,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t state_q, state_d;

  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;

  logic stop_good, stop_bad;
  logic good_q, bad_q;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;

  uart_sync2 #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (Rx),
    .q_o   (rx_s)
  );

  // State register: any reset abandons a partial frame
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start check at half-bit, then one full bit period per sample
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (timer_q == HALF_LAST) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (timer_q == BIT_LAST && idx_q == IDX_LAST) state_d = STOP;
      end
      STOP: begin
        if (timer_q == BIT_LAST) state_d = rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-state datapath: timer, bit index, LSB-first shift and stop-bit verdict
  always_comb begin
    timer_d   = timer_q + TW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        idx_d   = '0;
      end
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IW'(1);
        end
      end
      STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          stop_good = rx_s;
          stop_bad  = !rx_s;
        end
      end
      WAIT_IDLE: begin
        timer_d = '0;
      end
      default: begin
        timer_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Datapath registers plus the registered stop-bit verdict strobes
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      good_q  <= stop_good;
      bad_q   <= stop_bad;
    end
  end

  // Holding register: a same-cycle consume frees room for the new byte
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= bad_q;
      if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (good_q) begin
        if (!valid_q || rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign databus_write = data_q;
  assign rx_valid      = valid_q;
  assign frame_err     = ferr_q;
  assign overrun       = ovr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at default parameters (16 clocks/bit).
module tb_uart_rx_frame;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] databus_write;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int edgeCnt = 0;
  int frameE0 = 0;

  int  validRises = 0;
  int  validCycles = 0;
  int  lastValidRise = -1;
  int  errCycles = 0;
  int  lastErrEdge = -1;
  int  busyCycles = 0;
  logic prevValid = 1'b0;

  uart_rx_frame dut (
    .clk          (clk),
    .reset        (reset),
    .Rx           (Rx),
    .databus_write(databus_write),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Numbers rising edges so event times can be compared with E0-relative timing
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Passive monitor on the falling edge, tallying output activity per edge
  always @(negedge clk) begin
    if (rx_valid && !prevValid) begin
      validRises++;
      lastValidRise = edgeCnt;
    end
    if (rx_valid) validCycles++;
    prevValid = rx_valid;
    if (frame_err) begin
      errCycles++;
      lastErrEdge = edgeCnt;
    end
    if (busy) busyCycles++;
  end

  // Drives one complete frame; stopLow > 0 holds the stop bit low that many clocks first
  task automatic applyStimulus(input logic [7:0] b, input int stopLow);
    @(posedge clk); #1;
    Rx = 1'b0;
    frameE0 = edgeCnt + 1;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 Rx = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1;
    if (stopLow > 0) begin
      Rx = 1'b0;
      repeat (stopLow) @(posedge clk);
      #1;
    end
    Rx = 1'b1;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    Rx = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (databus_write !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", databus_write); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_good_frame();
    int v0, vc0, e0, b0;
    rx_ready = 1'b1;
    v0 = validRises; vc0 = validCycles; e0 = errCycles; b0 = busyCycles;
    applyStimulus(8'hA5, 0);
    @(negedge clk);
    checks++; if (databus_write !== 8'hA5) begin errors++; $display("[TB] FAIL good_data: got %h expected a5", databus_write); end
    checks++; if (validRises - v0 != 1) begin errors++; $display("[TB] FAIL good_rises: got %0d expected 1", validRises - v0); end
    checks++; if (lastValidRise != frameE0 + 155) begin errors++; $display("[TB] FAIL good_valid_time: got edge %0d expected %0d", lastValidRise, frameE0 + 155); end
    checks++; if (validCycles - vc0 != 1) begin errors++; $display("[TB] FAIL good_valid_width: got %0d expected 1", validCycles - vc0); end
    checks++; if (errCycles - e0 != 0) begin errors++; $display("[TB] FAIL good_ferr: got %0d expected 0", errCycles - e0); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL good_overrun: got %b expected 0", overrun); end
    checks++; if (busyCycles - b0 != 152) begin errors++; $display("[TB] FAIL good_busy_len: got %0d expected 152", busyCycles - b0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL good_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_glitch();
    int v0, e0, b0;
    v0 = validRises; e0 = errCycles; b0 = busyCycles;
    @(posedge clk); #1 Rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 Rx = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    checks++; if (validRises - v0 != 0) begin errors++; $display("[TB] FAIL glitch_valid: got %0d expected 0", validRises - v0); end
    checks++; if (errCycles - e0 != 0) begin errors++; $display("[TB] FAIL glitch_ferr: got %0d expected 0", errCycles - e0); end
    checks++; if (busyCycles - b0 != 8) begin errors++; $display("[TB] FAIL glitch_busy_len: got %0d expected 8", busyCycles - b0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_frame_error();
    int v0, e0;
    rx_ready = 1'b1;
    v0 = validRises; e0 = errCycles;
    applyStimulus(8'h3C, 40);
    @(negedge clk);
    checks++; if (errCycles - e0 != 1) begin errors++; $display("[TB] FAIL ferr_count: got %0d expected 1", errCycles - e0); end
    checks++; if (lastErrEdge != frameE0 + 155) begin errors++; $display("[TB] FAIL ferr_time: got edge %0d expected %0d", lastErrEdge, frameE0 + 155); end
    checks++; if (validRises - v0 != 0) begin errors++; $display("[TB] FAIL ferr_valid: got %0d expected 0", validRises - v0); end
    checks++; if (databus_write !== 8'hA5) begin errors++; $display("[TB] FAIL ferr_data_kept: got %h expected a5", databus_write); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ferr_busy_end: got %b expected 0", busy); end
    applyStimulus(8'h5A, 0);
    @(negedge clk);
    checks++; if (databus_write !== 8'h5A) begin errors++; $display("[TB] FAIL ferr_next_data: got %h expected 5a", databus_write); end
    checks++; if (validRises - v0 != 1) begin errors++; $display("[TB] FAIL ferr_next_valid: got %0d expected 1", validRises - v0); end
    checks++; if (errCycles - e0 != 1) begin errors++; $display("[TB] FAIL ferr_next_ferr: got %0d expected 1", errCycles - e0); end
  endtask

  task automatic test_back_to_back_overrun();
    rx_ready = 1'b0;
    applyStimulus(8'h11, 0);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_first_valid: got %b expected 1", rx_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_first_flag: got %b expected 0", overrun); end
    applyStimulus(8'h22, 0);
    @(negedge clk);
    checks++; if (databus_write !== 8'h11) begin errors++; $display("[TB] FAIL ovr_data: got %h expected 11", databus_write); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_valid: got %b expected 1", rx_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag: got %b expected 1", overrun); end
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_consume_valid: got %b expected 0", rx_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_consume_flag: got %b expected 0", overrun); end
    checks++; if (databus_write !== 8'h11) begin errors++; $display("[TB] FAIL ovr_consume_data: got %h expected 11", databus_write); end
  endtask

  task automatic test_simultaneous();
    rx_ready = 1'b0;
    applyStimulus(8'h66, 0);
    @(negedge clk);
    checks++; if (databus_write !== 8'h66) begin errors++; $display("[TB] FAIL simul_first_data: got %h expected 66", databus_write); end
    fork
      applyStimulus(8'h77, 0);
      begin
        @(posedge clk); #2;
        repeat (155) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    @(negedge clk);
    checks++; if (databus_write !== 8'h77) begin errors++; $display("[TB] FAIL simul_data: got %h expected 77", databus_write); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL simul_valid: got %b expected 1", rx_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL simul_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] partial;
    int v0;
    partial = 8'h96;
    rx_ready = 1'b0;
    @(posedge clk); #1 Rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (CPB) @(posedge clk);
      #1 Rx = partial[i];
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1; Rx = 1'b1;
    @(negedge clk);
    checks++; if (databus_write !== 8'h00) begin errors++; $display("[TB] FAIL mid_data: got %h expected 00", databus_write); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_ferr: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL mid_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    repeat (40) @(posedge clk);
    rx_ready = 1'b1;
    v0 = validRises;
    applyStimulus(8'hC3, 0);
    @(negedge clk);
    checks++; if (databus_write !== 8'hC3) begin errors++; $display("[TB] FAIL mid_next_data: got %h expected c3", databus_write); end
    checks++; if (validRises - v0 != 1) begin errors++; $display("[TB] FAIL mid_next_valid: got %0d expected 1", validRises - v0); end
    checks++; if (lastValidRise != frameE0 + 155) begin errors++; $display("[TB] FAIL mid_next_time: got edge %0d expected %0d", lastValidRise, frameE0 + 155); end
  endtask

  // Runs every scenario in order, then reports the totals
  initial begin
    $display("[TB] uart_rx_frame directed bench starting");
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back_overrun();
    test_simultaneous();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
